edge_event_arbiter: RTL
=======================

Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller: tracks N level inputs, detects both rising and falling edges per channel, and holds each edge as a pending event.
- Pending events are shared onto one registered event output with a valid/ready handshake. A round-robin arbiter picks the channel.
- Sits between synchronised switch/sensor levels and the consumer logic (display/counter FSMs). Replaces per-channel tick wiring with one serialised event stream.

Parameters:
- N, 4, number of level channels (2..16)
- IDW, 2, width of ev_id; must satisfy 2**IDW >= N

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- level  in  N  channel levels, already synchronous to clk
- en  in  N  per-channel edge capture enable
- ev_ready  in  1  consumer accepts the presented event
- clr_overrun  in  N  write-1-to-clear mask for overrun bits
- ev_valid  out  1  event presented
- ev_id  out  IDW  channel number of the presented event
- ev_rise  out  1  1 = rising edge, 0 = falling edge
- overrun  out  N  sticky per-channel lost-event flags

Behaviour:
- Reset state: clk is the single clock. Asynchronous active-high reset clears the following immediately, not waiting for a clock edge: level_q, pend, pol, overrun, ev_valid, ev_id, ev_rise; last_grant=N-1 (so channel 0 has first priority).
- Reset in mid-handshake: ev_valid drops at once, and the in-flight event is discarded.
- Level history: level_q[i] <= level[i] every cycle, regardless of en.
- Edge detection: edge[i] = en[i] & (level[i] != level_q[i]); polarity = level[i].
- Level high at reset release: level_q resets to 0, so a level already high when reset releases yields a rising event if en=1.
- Pending store: on edge[i], pend[i] <= 1 and pol[i] <= level[i] at the same clock edge.
- Edge while pend[i] is already set and channel i is not being loaded this cycle:
  - pol[i] is overwritten with the newer polarity.
  - overrun[i] <= 1.
  - Only one event remains pending.
- Edge on channel i in the same cycle that channel i is loaded to the output: the new edge re-arms pend[i]. No overrun.
- en[i]=0: no new edges captured on channel i. An existing pend[i] is kept and still served.
- Output FSM, two states:
  - IDLE: ev_valid=0. If any pend is set, load the arbiter winner into ev_id/ev_rise, clear that pend bit, set ev_valid=1, go to PRESENT.
  - PRESENT: ev_valid=1. ev_id/ev_rise stay stable while ev_ready=0. On ev_ready=1:
    - if any pend is set, load the next winner at the same edge (back-to-back, ev_valid stays 1);
    - otherwise go to IDLE.
- Arbiter: search pend starting at (last_grant+1) mod N, wrapping. The first set bit wins. last_grant updates to the winner on every load.
- Latency: edge sampled at clock edge t → pend set at t → earliest ev_valid at t+1.
- Throughput: sustained rate of 1 event/cycle with ev_ready held high.
- ev_ready while ev_valid=0 is ignored.
- overrun[i] stays set until a cycle with clr_overrun[i]=1. If set and clear occur in the same cycle, set wins.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset release with level=4'b0000, en=4'b1111, then level[2] 0→1 at cycle 5 with ev_ready=1 → ev_valid=1 at cycle 6, ev_id=2, ev_rise=1, for exactly 1 cycle; then level[2] 1→0 → one event ev_id=2, ev_rise=0.
- level 4'b0000→4'b1111 in one cycle, ev_ready=1 → four consecutive valid cycles with ev_id 0,1,2,3 and ev_rise=1; ev_valid falls on the fifth cycle.
- ev_ready=0, level[1] toggles 0→1 then 1→0 on successive cycles while pend[1] is set → overrun[1]=1 and ev_rise=0 when channel 1 is finally presented.
- Pulse clr_overrun[1]=1 → overrun[1]=0 next cycle.
- Set and clear overrun on the same cycle → overrun stays 1.
- en=4'b1110, toggle level[0] → no event. Then en[0]=1 and toggle again → event ev_id=0.
- ev_valid=1 with ev_ready=0 for 10 cycles → ev_id/ev_rise unchanged throughout. Assert reset mid-hold → ev_valid=0 asynchronously; after release with level unchanged from 0 → no spurious events.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: captures rising/falling edges per channel
// and serialises them onto one registered valid/ready stream via round-robin.
module edge_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   level,
  input  logic [N-1:0]   en,
  input  logic           ev_ready,
  input  logic [N-1:0]   clr_overrun,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  output logic           ev_rise,
  output logic [N-1:0]   overrun
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   level_q, pend, pol;
  logic [N-1:0]   edge_det, load_mask, pend_nxt, ovr_set;
  logic [IDW-1:0] last_grant, win_id;
  logic           load, hit;
  int             idx;

  assign edge_det = en & (level ^ level_q);
  assign ev_valid = (state == PRESENT);

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    win_id = '0;
    hit    = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!hit && pend[idx]) begin
        hit    = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          load      = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ev_ready) begin
          if (|pend) load = 1'b1;
          else       state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A fresh edge on the channel being loaded re-arms it rather than overrunning.
  always_comb begin
    load_mask = load ? ({{(N-1){1'b0}}, 1'b1} << win_id) : '0;
    pend_nxt  = (pend & ~load_mask) | edge_det;
    ovr_set   = edge_det & pend & ~load_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= '0;
      pend       <= '0;
      pol        <= '0;
      overrun    <= '0;
      ev_id      <= '0;
      ev_rise    <= 1'b0;
      last_grant <= IDW'(N - 1);
    end else begin
      level_q <= level;
      pend    <= pend_nxt;
      pol     <= (pol & ~edge_det) | (level & edge_det);
      overrun <= (overrun & ~clr_overrun) | ovr_set;
      if (load) begin
        ev_id      <= win_id;
        ev_rise    <= pol[win_id];
        last_grant <= win_id;
      end
    end
  end

endmodule
